seq_alu: RTL and testbench
==========================

// Module: seq_alu
//
// PURPOSE
// Parametrised multi-cycle ALU; successor to the 8-bit combinational add/mult ALU.
// - Operand width WIDTH; opcodes ADD, SUB, MUL, plus one reserved code.
// - Start/busy/done handshake; result register holds until the next completion.
// - MUL is an iterative shift-add engine (one partial product per clock), not a combinational multiplier.
// - Sits between the operand registers and the result display/bus logic of the datapath.
//
// PARAMETERS
// WIDTH   8   operand width in bits, >= 2; result width is 2*WIDTH
//
// PORTS
// clk     in   1         single clock, rising edge
// rst     in   1         synchronous reset, active-high
// start   in   1         request; sampled only while busy=0
// opcode  in   2         00 ADD, 01 SUB, 10 MUL, 11 reserved
// opA     in   WIDTH     operand A, unsigned for ADD/MUL, two's complement for SUB result
// opB     in   WIDTH     operand B
// busy    out  1         operation in progress; start ignored while high
// done    out  1         one-cycle pulse: res updated this cycle
// res     out  2*WIDTH   registered result
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): res=0, done=0, busy=0, FSM->IDLE; any MUL in flight is aborted with no done.
// - FSM states: IDLE, MUL_RUN, DONE.
// - IDLE: at an edge with start=1, opcode/opA/opB are captured (capture edge E0); later input changes have no effect.
// - ADD: res = {{WIDTH-1}0, carry, sum}, zero-extended to 2*WIDTH. After E0: done=1, busy=0 (latency 1).
// - SUB: res = opA - opB, computed in 2*WIDTH bits, sign-extended. Latency 1, as for ADD.
// - Reserved 11: res = 0. Latency 1, as for ADD.
// - MUL (unsigned): after E0, busy=1 and the state is MUL_RUN.
//   - Edges E1..E_WIDTH each process one bit of opB, LSB first.
//   - After E_WIDTH: res = opA*opB (full 2*WIDTH bits), done=1, busy=0.
//   - Latency is WIDTH edges from E0; busy is high for exactly WIDTH cycles.
// - DONE: lasts one cycle; done=1 and busy=0. A start seen in this cycle is accepted (back-to-back issue), and the next op captures at that edge.
//   - If no start is seen, the FSM returns to IDLE and done falls to 0.
// - start while busy=1 is dropped silently; there is no queueing.
// - res changes only on a completion edge or on reset; it is stable between completions.
// - Operand edge cases need no special handling:
//   - operand 0 still takes the full WIDTH cycles for MUL;
//   - all-ones operands must not overflow 2*WIDTH.
//
// STRUCTURE
// - Shared include alu_defs.vh:
//   - `define ALU_OP_ADD 2'b00, ALU_OP_SUB 2'b01, ALU_OP_MUL 2'b10, ALU_OP_RSV 2'b11
//   - FSM state encodings: ST_IDLE, ST_MUL_RUN, ST_DONE
// - Sub-module seq_mult (param WIDTH), instantiated once.
//   - Interface: load, step, multiplicand, multiplier, product[2*WIDTH-1:0], last (high on the final step).
//   - Owns the accumulator, shifted multiplicand and bit counter.
// - ADD/SUB logic and the FSM live in seq_alu; the res register is owned by seq_alu.
//
// TESTING
// 1. WIDTH=8, ADD opA=8'hFF, opB=8'h01, start 1 cycle
//    -> one cycle later done=1, res=16'h0100, busy never high.
// 2. WIDTH=8, SUB opA=8'h05, opB=8'h07 -> done after 1 cycle, res=16'hFFFE.
// 3. WIDTH=8, MUL opA=8'hFF, opB=8'hFF -> busy high 8 cycles, then done=1 with res=16'hFE01.
//    - Pulse start=1 with opcode=ADD at cycle 3 of the MUL: it is ignored (exactly one done, res=16'hFE01).
// 4. WIDTH=8, MUL 8'h0C x 8'h0A with rst=1 at cycle 4 of the MUL
//    -> busy=0, done=0, res=0 after the reset edge, no later done.
//    - Then ADD 8'h01 + 8'h02 -> res=16'h0003.
// 5. WIDTH=8, back-to-back: MUL 8'h03 x 8'h04, with start (ADD 8'h10 + 8'h20) held high during the done cycle
//    -> res=16'h000C, then the next cycle done=1 with res=16'h0030.
// 6. WIDTH=16, MUL 16'hFFFF x 16'h0002
//    -> busy high 16 cycles, res=32'h0001FFFE.
//    - Reserved opcode 2'b11 -> done after 1 cycle, res=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the operand registers and the sequential ALU.
interface seq_alu_if #(parameter int WIDTH = 8);

  logic               start;
  logic [1:0]         opcode;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;

  modport master (
    output start, opcode, opA, opB,
    input  busy, done, res
  );

  modport slave (
    input  start, opcode, opA, opB,
    output busy, done, res
  );

endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per step, multiplier LSB first.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               last_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // product_o includes the partial product of the current step, so the
  // owner can latch the full result on the same edge as the final step.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign product_o = acc_d;
  assign last_o    = step_i && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, multiplicand_i};
      mplier_q <= multiplier_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/reserved, iterative MUL, start/busy/done handshake.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  state_e             state_q;
  state_e             state_d;
  logic [2*WIDTH-1:0] res_q;
  logic [2*WIDTH-1:0] res_d;
  logic               multLoad;
  logic               multStep;
  logic               multLast;
  logic [2*WIDTH-1:0] multProduct;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] subDiff;

  assign addSum  = {1'b0, bus.opA} + {1'b0, bus.opB};
  assign subDiff = {{WIDTH{1'b0}}, bus.opA} - {{WIDTH{1'b0}}, bus.opB};

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk            (clk),
    .rst            (rst),
    .load_i         (multLoad),
    .step_i         (multStep),
    .multiplicand_i (bus.opA),
    .multiplier_i   (bus.opB),
    .product_o      (multProduct),
    .last_o         (multLast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  // DONE accepts a new request just like IDLE, giving back-to-back issue.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    multLoad = 1'b0;
    multStep = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          case (opcode_e'(bus.opcode))
            OP_ADD: begin
              res_d   = {{(WIDTH-1){1'b0}}, addSum};
              state_d = ST_DONE;
            end
            OP_SUB: begin
              res_d   = subDiff;
              state_d = ST_DONE;
            end
            OP_MUL: begin
              multLoad = 1'b1;
              state_d  = ST_MUL_RUN;
            end
            default: begin
              res_d   = '0;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL_RUN: begin
        multStep = 1'b1;
        if (multLast) begin
          res_d   = multProduct;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_MUL_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.res  = res_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;

  localparam int TIMEOUT = 40;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expRes;
    int          expBusy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(8))  a8 ();
  seq_alu_if #(.WIDTH(16)) a16 ();

  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(a8));
  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(a16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request cycle, then scrambles the inputs to prove they were captured.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a8.start  = 1'b1;
    a8.opcode = op;
    a8.opA    = a;
    a8.opB    = b;
    @(negedge clk);
    a8.start  = 1'b0;
    a8.opcode = ~op;
    a8.opA    = ~a;
    a8.opB    = ~b;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expRes, input int expBusy);
    int busyCnt = 0;
    int samples = 1;
    while (!a8.done && samples < TIMEOUT) begin
      if (a8.busy) busyCnt++;
      @(negedge clk);
      samples++;
    end
    checkVal({name, " done"}, {31'b0, a8.done}, 32'd1);
    checkVal({name, " busyCycles"}, busyCnt, expBusy);
    checkVal({name, " latency"}, samples, expBusy + 1);
    checkVal({name, " busyAtDone"}, {31'b0, a8.busy}, 32'd0);
    checkVal({name, " res"}, {16'b0, a8.res}, {16'b0, expRes});
    @(negedge clk);
    checkVal({name, " donePulse"}, {31'b0, a8.done}, 32'd0);
    checkVal({name, " resHold"}, {16'b0, a8.res}, {16'b0, expRes});
  endtask

  initial begin
    vec_t vecs[$];
    int   doneCnt;
    int   busyCnt;
    int   samples;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    a8.start = 1'b0;  a8.opcode = 2'b00;  a8.opA = '0;  a8.opB = '0;
    a16.start = 1'b0; a16.opcode = 2'b00; a16.opA = '0; a16.opB = '0;

    vecs.push_back('{"addCarry", 2'b00, 8'hFF, 8'h01, 16'h0100, 0});
    vecs.push_back('{"subNeg",   2'b01, 8'h05, 8'h07, 16'hFFFE, 0});
    vecs.push_back('{"mulMax",   2'b10, 8'hFF, 8'hFF, 16'hFE01, 8});
    vecs.push_back('{"add8080",  2'b00, 8'h80, 8'h80, 16'h0100, 0});
    vecs.push_back('{"subZeroFF",2'b01, 8'h00, 8'hFF, 16'hFF01, 0});
    vecs.push_back('{"mulZero",  2'b10, 8'h00, 8'hAB, 16'h0000, 8});
    vecs.push_back('{"mul0C0A",  2'b10, 8'h0C, 8'h0A, 16'h0078, 8});
    vecs.push_back('{"rsv",      2'b11, 8'h12, 8'h34, 16'h0000, 0});
    vecs.push_back('{"subPos",   2'b01, 8'hFF, 8'h01, 16'h00FE, 0});
    vecs.push_back('{"addZero",  2'b00, 8'h00, 8'h00, 16'h0000, 0});
    vecs.push_back('{"mul1234",  2'b10, 8'h12, 8'h34, 16'h03A8, 8});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkVal("resetBusy", {31'b0, a8.busy}, 32'd0);
    checkVal("resetDone", {31'b0, a8.done}, 32'd0);
    checkVal("resetRes",  {16'b0, a8.res}, 32'd0);
    checkVal("resetRes16", a16.res, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].expRes, vecs[i].expBusy);
    end

    // A start during MUL is dropped: exactly one completion over a long window.
    applyStimulus(2'b10, 8'hFF, 8'hFF);
    doneCnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        a8.start = 1'b1; a8.opcode = 2'b00; a8.opA = 8'h01; a8.opB = 8'h01;
      end else begin
        a8.start = 1'b0;
      end
      if (a8.done) doneCnt++;
      @(negedge clk);
    end
    checkVal("ignoreDoneCount", doneCnt, 32'd1);
    checkVal("ignoreRes", {16'b0, a8.res}, 32'h0000FE01);

    // Reset in the middle of a MUL aborts it without a completion.
    applyStimulus(2'b10, 8'h0C, 8'h0A);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkVal("abortBusy", {31'b0, a8.busy}, 32'd0);
    checkVal("abortDone", {31'b0, a8.done}, 32'd0);
    checkVal("abortRes",  {16'b0, a8.res}, 32'd0);
    doneCnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (a8.done) doneCnt++;
      @(negedge clk);
    end
    checkVal("abortNoDone", doneCnt, 32'd0);
    applyStimulus(2'b00, 8'h01, 8'h02);
    checkOutput("addAfterAbort", 16'h0003, 0);

    // Back-to-back: ADD issued during the MUL done cycle.
    applyStimulus(2'b10, 8'h03, 8'h04);
    samples = 1;
    while (!a8.done && samples < TIMEOUT) begin
      @(negedge clk);
      samples++;
    end
    checkVal("b2bMulDone", {31'b0, a8.done}, 32'd1);
    checkVal("b2bMulRes", {16'b0, a8.res}, 32'h0000000C);
    a8.start = 1'b1; a8.opcode = 2'b00; a8.opA = 8'h10; a8.opB = 8'h20;
    @(negedge clk);
    a8.start = 1'b0;
    checkVal("b2bAddDone", {31'b0, a8.done}, 32'd1);
    checkVal("b2bAddRes", {16'b0, a8.res}, 32'h00000030);
    @(negedge clk);
    checkVal("b2bIdle", {31'b0, a8.done}, 32'd0);

    // WIDTH=16 multiply and reserved opcode.
    @(negedge clk);
    a16.start = 1'b1; a16.opcode = 2'b10; a16.opA = 16'hFFFF; a16.opB = 16'h0002;
    @(negedge clk);
    a16.start = 1'b0; a16.opA = 16'h1234; a16.opB = 16'h5678;
    busyCnt = 0;
    samples = 1;
    while (!a16.done && samples < TIMEOUT) begin
      if (a16.busy) busyCnt++;
      @(negedge clk);
      samples++;
    end
    checkVal("w16MulDone", {31'b0, a16.done}, 32'd1);
    checkVal("w16MulBusy", busyCnt, 32'd16);
    checkVal("w16MulRes", a16.res, 32'h0001FFFE);
    @(negedge clk);
    a16.start = 1'b1; a16.opcode = 2'b11; a16.opA = 16'h00AA; a16.opB = 16'h0055;
    @(negedge clk);
    a16.start = 1'b0;
    checkVal("w16RsvDone", {31'b0, a16.done}, 32'd1);
    checkVal("w16RsvBusy", {31'b0, a16.busy}, 32'd0);
    checkVal("w16RsvRes", a16.res, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
